// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Widths shared by the UART receiver, transmitter and byte FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr
// Brief    : Read/write pointer and occupancy unit for a circular FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr
  import uart_pkg::*;
#(
  parameter int AW = DEFAULT_DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  output logic [AW:0] wr_ptr,
  output logic [AW:0] rd_ptr,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        push_ok,
  output logic        pop_ok
);

  localparam logic [AW:0] c_ptr_one = 1;

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  // The extra pointer MSB separates a full ring from an empty one.
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count   = r_wr_ptr - r_rd_ptr;

  // A pop on a full ring frees the slot that the same-cycle push reuses.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);

  assign wr_ptr  = r_wr_ptr;
  assign rd_ptr  = r_rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Receive byte FIFO with interrupt request and sticky drop tracking.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_update,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  ack,
  output logic                  irr,
  output logic [BYTE_W-1:0]     r_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            drop_cnt,
  input  logic                  clr_ovf
);

  localparam int          c_depth    = 2 ** DEPTH_LOG2;
  localparam logic [7:0]  c_drop_max = 8'hFF;
  localparam logic [7:0]  c_drop_one = 8'h01;

  logic [BYTE_W-1:0]   r_mem [c_depth];
  logic                r_overflow;
  logic [7:0]          r_drop_cnt;

  logic [DEPTH_LOG2:0] w_wr_ptr;
  logic [DEPTH_LOG2:0] w_rd_ptr;
  logic                w_full;
  logic                w_empty;
  logic                w_push_ok;
  logic                w_pop_ok;
  logic                w_drop;
  logic                w_unused_ptr_msbs;

  fifo_ptr #(
    .AW      (DEPTH_LOG2)
  ) u_fifo_ptr (
    .clk     (clk),
    .reset   (reset),
    .push    (uart_update),
    .pop     (ack),
    .wr_ptr  (w_wr_ptr),
    .rd_ptr  (w_rd_ptr),
    .full    (w_full),
    .empty   (w_empty),
    .count   (count),
    .push_ok (w_push_ok),
    .pop_ok  (w_pop_ok)
  );

  assign w_unused_ptr_msbs = ^{w_wr_ptr[DEPTH_LOG2], w_rd_ptr[DEPTH_LOG2], w_pop_ok};

  // A byte is lost only when the ring is full and no same-cycle pop makes room.
  assign w_drop = uart_update && w_full && !ack;

  always_ff @(posedge clk) begin
    if (reset && w_push_ok) begin
      r_mem[w_wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
    end
  end

  // A drop in the same cycle as clr_ovf restarts the tally at one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf)
        r_drop_cnt <= c_drop_one;
      else if (r_drop_cnt != c_drop_max)
        r_drop_cnt <= r_drop_cnt + c_drop_one;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign irr      = !w_empty;
  assign r_data   = w_empty ? '0 : r_mem[w_rd_ptr[DEPTH_LOG2-1:0]];
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule : uart_rx_fifo
`default_nettype wire
